// File: rtl/pedal_pkg.sv
// Types and constants shared across the pedal datapath: converter frame front end,
// compression and memory stages.
package pedal_pkg;

    localparam int DATA_W            = 16;
    localparam int CLK_DIV_DEF       = 2;
    localparam int CS_SETUP_DEF      = 2;
    localparam int CS_HOLD_DEF       = 2;
    localparam int SAMPLE_PERIOD_DEF = 1042;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } spi_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sample_timer.sv
// Audio sample-period timer: free-runs while enabled, held at zero otherwise,
// and emits a registered one-cycle tick once per period.
module sample_timer import pedal_pkg::*; #(
    parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(SAMPLE_PERIOD);

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             at_end;

    always_comb begin
        at_end  = (count_q == CNT_W'(SAMPLE_PERIOD - 1));
        count_d = '0;
        tick_d  = 1'b0;
        if (enable) begin
            count_d = at_end ? '0 : count_q + 1'b1;
            tick_d  = at_end;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/adc_dac_spi_frame.sv
// One full-duplex SPI frame per sample period: DAC word out on mosi, ADC word in on
// miso, then the new ADC word is presented with a one-cycle adc_clock strobe.
//
// state | meaning
// IDLE  | cs high, waiting for a sample tick
// SETUP | cs low, first DAC bit on mosi, CS_SETUP cycles
// SHIFT | DATA_W sclk periods (low then high, CLK_DIV cycles each)
// HOLD  | cs still low after last sclk fall, CS_HOLD cycles
// DONE  | cs high, adc updated, adc_clock pulsed
module adc_dac_spi_frame import pedal_pkg::*; #(
    parameter int DATA_W        = pedal_pkg::DATA_W,
    parameter int CLK_DIV       = CLK_DIV_DEF,
    parameter int CS_SETUP      = CS_SETUP_DEF,
    parameter int CS_HOLD       = CS_HOLD_DEF,
    parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] dac,
    input  logic              miso,
    input  logic              clear_overrun,
    output logic              sclk,
    output logic              mosi,
    output logic              cs,
    output logic [DATA_W-1:0] adc,
    output logic              adc_clock,
    output logic              busy,
    output logic              overrun
);

    localparam int PH_W  = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic tick;

    spi_state_e        state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] adc_q, adc_d;
    logic              sclk_q, sclk_d;
    logic              cs_q, cs_d;
    logic              adc_clock_q, adc_clock_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    sample_timer #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_sample_timer (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        adc_d       = adc_q;
        sclk_d      = sclk_q;
        cs_d        = cs_q;
        adc_clock_d = 1'b0;
        busy_d      = busy_q;

        // A tick that cannot start a frame is lost; setting outranks clearing.
        overrun_d = overrun_q;
        if (tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                busy_d = 1'b0;
                if (tick) begin
                    tx_d    = dac;
                    bit_d   = '0;
                    ph_d    = PH_W'(CS_SETUP - 1);
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (ph_q == '0) begin
                    ph_d    = PH_W'(CLK_DIV - 1);
                    state_d = ST_SHIFT;
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ph_q != '0) begin
                    ph_d = ph_q - 1'b1;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[DATA_W-2:0], miso};
                    ph_d   = PH_W'(CLK_DIV - 1);
                end else begin
                    sclk_d = 1'b0;
                    if (bit_q == LAST_BIT) begin
                        ph_d    = PH_W'(CS_HOLD - 1);
                        state_d = ST_HOLD;
                    end else begin
                        tx_d  = {tx_q[DATA_W-2:0], 1'b0};
                        bit_d = bit_q + 1'b1;
                        ph_d  = PH_W'(CLK_DIV - 1);
                    end
                end
            end
            ST_HOLD: begin
                if (ph_q == '0) begin
                    cs_d        = 1'b1;
                    adc_d       = rx_q;
                    adc_clock_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ph_q        <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            adc_q       <= '0;
            sclk_q      <= 1'b0;
            cs_q        <= 1'b1;
            adc_clock_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            adc_q       <= adc_d;
            sclk_q      <= sclk_d;
            cs_q        <= cs_d;
            adc_clock_q <= adc_clock_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    // The tx register's MSB is the line itself, so mosi is registered by construction.
    assign mosi      = tx_q[DATA_W-1];
    assign sclk      = sclk_q;
    assign cs        = cs_q;
    assign adc       = adc_q;
    assign adc_clock = adc_clock_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_dac_spi_frame.sv
// Bench for adc_dac_spi_frame: two instances (default period and a period shorter
// than a frame) share stimulus and are checked every cycle against a timing model.
module tb_adc_dac_spi_frame;

    localparam int DW        = 16;
    localparam int CD        = 2;
    localparam int CSS       = 2;
    localparam int CSH       = 2;
    localparam int LAT       = 1 + CSS + 2 * DW * CD + CSH;
    localparam int SHIFT_LEN = 2 * DW * CD;
    localparam int P0        = 1042;
    localparam int P1        = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear_overrun = 1'b0;
    logic [15:0] dac = 16'hA5C3;
    logic        loop_mode = 1'b1;
    logic [15:0] adc_word = 16'h0000;

    logic        sclk_w[2], mosi_w[2], cs_w[2], adc_clock_w[2], busy_w[2], overrun_w[2], miso_w[2];
    logic [15:0] adc_w[2];
    int          rc[2] = '{0, 0};
    logic        sclk_prev[2] = '{1'b0, 1'b0};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state
    logic        valid = 1'b0;
    logic        fr_on[2] = '{1'b0, 1'b0};
    int          t0[2] = '{0, 0};
    logic [15:0] txw[2] = '{16'h0, 16'h0};
    logic [15:0] rxw[2] = '{16'h0, 16'h0};
    logic [15:0] adc_e[2] = '{16'h0, 16'h0};
    logic        ovr_e[2] = '{1'b0, 1'b0};
    int          n[2] = '{0, 0};
    logic        tick_m[2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_dac_spi_frame #(.SAMPLE_PERIOD(P0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .dac(dac), .miso(miso_w[0]),
        .clear_overrun(clear_overrun), .sclk(sclk_w[0]), .mosi(mosi_w[0]), .cs(cs_w[0]),
        .adc(adc_w[0]), .adc_clock(adc_clock_w[0]), .busy(busy_w[0]), .overrun(overrun_w[0])
    );

    adc_dac_spi_frame #(.SAMPLE_PERIOD(P1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .dac(dac), .miso(miso_w[1]),
        .clear_overrun(clear_overrun), .sclk(sclk_w[1]), .mosi(mosi_w[1]), .cs(cs_w[1]),
        .adc(adc_w[1]), .adc_clock(adc_clock_w[1]), .busy(busy_w[1]), .overrun(overrun_w[1])
    );

    // Serial source: loopback or a model ADC presenting adc_word MSB first.
    assign miso_w[0] = loop_mode ? mosi_w[0] : ((rc[0] < 16) ? adc_word[15 - rc[0]] : 1'b0);
    assign miso_w[1] = loop_mode ? mosi_w[1] : ((rc[1] < 16) ? adc_word[15 - rc[1]] : 1'b0);

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (cs_w[u]) rc[u] <= 0;
            else if (sclk_w[u] && !sclk_prev[u]) rc[u] <= rc[u] + 1;
            sclk_prev[u] <= sclk_w[u];
        end
    end

    function automatic int period_of(input int u);
        return (u == 0) ? P0 : P1;
    endfunction

    task automatic chk(input string nm, input int u, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, u, cyc, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL timeout %s cyc=%0d got=no-event exp=event", nm, cyc);
    endtask

    // Compare the current cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int   k, s, b, sn;
            logic in_fr, e_sclk;
            k     = cyc - t0[u];
            in_fr = fr_on[u] && (k >= 1) && (k <= LAT);
            s     = k - 1 - CSS;
            if (valid) begin
                e_sclk = in_fr && (s >= 0) && (s < SHIFT_LEN) && (((s / CD) % 2) == 1);
                chk("cs", u, cs_w[u], !(in_fr && (k < LAT)));
                chk("sclk", u, sclk_w[u], e_sclk);
                chk("busy", u, busy_w[u], in_fr);
                chk("adc_clock", u, adc_clock_w[u], fr_on[u] && (k == LAT));
                chk("adc", u, adc_w[u], adc_e[u]);
                chk("overrun", u, overrun_w[u], ovr_e[u]);
                if (in_fr && (k < LAT)) begin
                    b = (s < 0) ? 0 : ((s >= SHIFT_LEN) ? DW - 1 : s / (2 * CD));
                    chk("mosi", u, mosi_w[u], txw[u][DW-1-b]);
                end
            end
            if (rst) begin
                fr_on[u]  = 1'b0;
                adc_e[u]  = 16'h0;
                ovr_e[u]  = 1'b0;
                n[u]      = 0;
                tick_m[u] = 1'b0;
            end else begin
                if (tick_m[u]) begin
                    if (in_fr) ovr_e[u] = 1'b1;
                    else begin
                        fr_on[u] = 1'b1;
                        t0[u]    = cyc;
                        txw[u]   = dac;
                    end
                end
                if (clear_overrun && !(tick_m[u] && in_fr)) ovr_e[u] = 1'b0;
                sn = (cyc + 1) - t0[u] - 1 - CSS;
                if (fr_on[u] && (sn >= 0) && (sn < SHIFT_LEN) && ((sn % (2 * CD)) == CD))
                    rxw[u] = {rxw[u][DW-2:0], miso_w[u]};
                if (fr_on[u] && ((cyc + 1) == t0[u] + LAT)) adc_e[u] = rxw[u];
                if (!enable) n[u] = 0;
                else n[u] = n[u] + 1;
                tick_m[u] = (n[u] > 0) && ((n[u] % period_of(u)) == 0);
            end
        end
        if (rst) valid = 1'b1;
    end

    task automatic wait_ack(input int lim, output int at, output int rises, output int changes);
        logic        prev;
        logic [15:0] a0;
        at = -1; rises = 0; changes = 0;
        prev = sclk_w[0];
        a0 = adc_w[0];
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (sclk_w[0] && !prev) rises++;
            prev = sclk_w[0];
            if (adc_clock_w[0]) begin
                at = cyc;
                break;
            end
            if (adc_w[0] !== a0) changes++;
        end
        if (at < 0) timeout("adc_clock");
    endtask

    task automatic wait_cs_low(input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (!cs_w[0]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) timeout("cs_fall");
    endtask

    task automatic wait_rises(input int nr, input int lim);
        logic prev;
        int   cnt;
        cnt = 0;
        prev = sclk_w[0];
        for (int i = 0; i < lim && cnt < nr; i++) begin
            @(posedge clk); #1;
            if (sclk_w[0] && !prev) cnt++;
            prev = sclk_w[0];
        end
        if (cnt < nr) timeout("sclk_rise");
    endtask

    initial begin
        int   c0, at, rises, changes, r, pulses, falls, found;
        logic prev_cs, busy1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 0, cs_w[0], 1'b1);
        chk("rst_sclk", 0, sclk_w[0], 1'b0);
        chk("rst_mosi", 0, mosi_w[0], 1'b0);
        chk("rst_adc", 0, adc_w[0], 16'h0000);
        chk("rst_adc_clock", 0, adc_clock_w[0], 1'b0);
        chk("rst_busy", 0, busy_w[0], 1'b0);
        chk("rst_overrun", 0, overrun_w[0], 1'b0);

        // loopback frame, first tick one period after enable
        rst = 1'b0; enable = 1'b1; c0 = cyc;
        wait_ack(1300, at, rises, changes);
        chk("tick_plus_latency", 0, at - c0, 32'd1111);
        chk("loop_adc", 0, adc_w[0], 16'hA5C3);
        chk("sclk_rises", 0, rises, 32'd16);
        chk("no_overrun", 0, overrun_w[0], 1'b0);

        // model ADC words
        loop_mode = 1'b0; adc_word = 16'h8001;
        wait_ack(1100, at, rises, changes);
        chk("adc_8001", 0, adc_w[0], 16'h8001);
        adc_word = 16'h7FFE;
        wait_ack(1100, at, rises, changes);
        chk("adc_stable", 0, changes, 32'd0);
        chk("adc_7ffe", 0, adc_w[0], 16'h7FFE);

        // dac change mid-frame is ignored
        loop_mode = 1'b1; dac = 16'h1234;
        wait_cs_low(1100, at);
        wait_rises(3, 100);
        dac = 16'hFFFF;
        wait_ack(200, at, rises, changes);
        chk("dac_latched", 0, adc_w[0], 16'h1234);

        // reset in the middle of SHIFT
        dac = 16'h0F0F;
        wait_cs_low(1100, at);
        wait_rises(7, 100);
        rst = 1'b1; r = cyc;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_cs", 0, cs_w[0], 1'b1);
        chk("midrst_sclk", 0, sclk_w[0], 1'b0);
        chk("midrst_adc", 0, adc_w[0], 16'h0000);
        chk("midrst_adc_clock", 0, adc_clock_w[0], 1'b0);
        chk("midrst_busy", 0, busy_w[0], 1'b0);
        wait_cs_low(1200, at);
        chk("restart_delay", 0, at - r, 32'd1044);

        // enable dropped while the frame is running
        repeat (10) @(posedge clk);
        #1;
        enable = 1'b0;
        pulses = 0; falls = 0; prev_cs = cs_w[0];
        for (int i = 0; i < 1300; i++) begin
            @(posedge clk); #1;
            if (adc_clock_w[0]) pulses++;
            if (prev_cs && !cs_w[0]) falls++;
            prev_cs = cs_w[0];
        end
        chk("drop_pulses", 0, pulses, 32'd1);
        chk("drop_cs_falls", 0, falls, 32'd0);
        chk("drop_adc", 0, adc_w[0], 16'h0F0F);

        // overrun on the short-period instance
        enable = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("ovr_set", 1, overrun_w[1], 1'b1);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (!tick_m[1]) begin found = 1; break; end
            @(posedge clk); #1;
        end
        if (found == 0) timeout("quiet_cycle");
        clear_overrun = 1'b1;
        @(posedge clk); #1;
        clear_overrun = 1'b0;
        chk("ovr_clear", 1, overrun_w[1], 1'b0);
        found = 0;
        for (int i = 0; i < 300; i++) begin
            busy1 = fr_on[1] && ((cyc - t0[1]) >= 1) && ((cyc - t0[1]) <= LAT);
            if (tick_m[1] && busy1) begin found = 1; break; end
            @(posedge clk); #1;
        end
        if (found == 0) timeout("dropped_tick");
        clear_overrun = 1'b1;
        @(posedge clk); #1;
        clear_overrun = 1'b0;
        chk("ovr_set_wins", 1, overrun_w[1], 1'b1);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
